srt_fp32_result_packer: RTL
===========================

// Module: srt_fp32_result_packer
// PURPOSE
// Downstream stage of the radix-4 SRT FP32 divider. Takes the raw fixed-point quotient, final-remainder
// status, pre-exponent, sign and special-case class from the divider core. Applies the negative-remainder
// correction, normalizes, rounds RNE and packs an IEEE-754 binary32 word plus exception flags.
// Handshake on both sides; processes one division at a time.
// PARAMETERS
// QW  28  quotient width: 2 integer bits + (QW-2) fraction bits; must be >= 28 (24 mant + guard + 1 sticky)
// EW  10  signed pre-exponent width (biased, ea-eb+127, before normalization)
// PORTS
// clk          in   1   clock
// rst          in   1   asynchronous reset, active-high
// in_valid     in   1   divider result available
// in_ready     out  1   packer can accept (high only in IDLE)
// in_quotient  in   QW  unsigned quotient, value = in_quotient / 2^(QW-2), range [0.5,2)
// in_rem_neg   in   1   final partial remainder negative -> quotient is 1 ulp too large
// in_rem_nz    in   1   final partial remainder nonzero (sticky source)
// in_exp       in   EW  signed biased pre-exponent
// in_sign      in   1   result sign (sa ^ sb)
// in_special   in   3   srt_fp32_pkg::special_e: NORMAL, ZERO, INF, QNAN, DIVZ
// out_valid    out  1   out_result/out_flags valid
// out_ready    in   1   consumer accepts
// out_result   out  32  packed binary32
// out_flags    out  5   {invalid, divzero, overflow, underflow, inexact}
// BEHAVIOUR
// - Reset (async, rst=1): state=IDLE, in_ready=1, out_valid=0, out_result=0, out_flags=0; all capture regs 0.
// - FSM: IDLE -> CORR -> NORM -> RND -> DONE -> IDLE.
//   IDLE: in_ready=1; in_valid&in_ready captures all inputs. Next state is CORR if NORMAL, otherwise DONE.
//   CORR: Q = in_rem_neg ? Q-1 : Q; sticky0 = in_rem_nz | in_rem_neg.
//   NORM: Q[QW-2]=1 -> mant=Q[QW-2:QW-25], guard=Q[QW-26], sticky=sticky0|OR(Q[QW-27:0]), exp=in_exp;
//         else -> mant=Q[QW-3:QW-26], guard=Q[QW-27], sticky=sticky0|OR(Q[QW-28:0]), exp=in_exp-1.
//   RND: up = guard & (sticky | mant[0]); mant+up carrying out of 24 bits -> mant=24'h800000, exp+1.
//        inexact=guard|sticky. exp>=255 -> {sign,8'hFF,23'h0}, overflow=1, inexact=1.
//        exp<=0 -> flush to {sign,31'h0}, underflow=1, inexact=1 (no subnormal output).
//        Else {sign, exp[7:0], mant[22:0]}.
//   Specials (written on the IDLE->DONE transition):
//     ZERO -> {sign,31'h0}; INF -> {sign,8'hFF,23'h0}; QNAN -> 32'h7FC00000 with invalid=1;
//     DIVZ -> {sign,8'hFF,23'h0} with divzero=1.
//   DONE: out_valid=1; result/flags held stable while out_ready=0. On out_ready, go to IDLE and
//         drop out_valid in the next cycle.
// - Latency: NORMAL path gives out_valid 4 cycles after acceptance; special path gives it 1 cycle after.
// - Throughput: in_ready=0 from acceptance until DONE handshake completes. No same-cycle accept+emit.
// - in_valid while not ready is ignored. The divider holds its data until in_ready.
// - out_result/out_flags update only when entering DONE. Outside DONE they keep their last value.
// - rst asserted mid-operation aborts immediately to reset state. The in-flight division is lost
//   and no out_valid pulse is produced.
// - Exponent arithmetic is done at EW+1 bits signed, so +/-1 adjustments never wrap.
// STRUCTURE
// - srt_fp32_pkg (shared with divider core/normalizer): special_e enum, state_e enum, FP32_BIAS=127,
//   FP32_QNAN=32'h7FC00000, FP32_EXP_MAX=8'hFF, flag bit index localparams.
// - One sub-module: rne_rounder_24 (combinational: mant, guard, sticky -> rounded mant, carry, inexact).
// - Top: FSM + capture/pipeline registers + packing mux.
// TESTING (QW=28, EW=10)
// 1. Q=28'h6000000 (1.5), exp=127, sign=0, rem_nz=0 -> 0x3FC00000, flags 0, out_valid 4 cycles after accept.
// 2. Q=28'h2AAAAAA, rem_nz=1, exp=127 (1/1.5) -> NORM exp 126, round up -> 0x3F2AAAAB, inexact=1.
// 3. Q=28'h4000001, rem_neg=1, exp=127 -> corrected 1.0 -> 0x3F800000, inexact=1.
// 4. Q=28'h7FFFFFF, exp=254 -> round carry to exp 255 -> 0x7F800000, overflow=1, inexact=1.
//    Also Q=28'h2000000, exp=1, sign=1 -> 0x80000000, underflow=1.
// 5. Specials: QNAN -> 0x7FC00000 invalid=1; DIVZ, sign=1 -> 0xFF800000 divzero=1; each 1 cycle after accept.
// 6. Hold out_ready=0 5 cycles: result stable, in_ready=0, new in_valid ignored.
//    Then rst pulse during NORM -> all outputs 0, in_ready=1, no out_valid.

Source files
------------

// File: rtl/srt_fp32_pkg.sv
// Shared types and constants for the radix-4 SRT FP32 divider.
// Used by the divider core, normalizer and result packer.
package srt_fp32_pkg;

  typedef enum logic [2:0] {
    SP_NORMAL = 3'd0,
    SP_ZERO   = 3'd1,
    SP_INF    = 3'd2,
    SP_QNAN   = 3'd3,
    SP_DIVZ   = 3'd4
  } special_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CORR = 3'd1,
    S_NORM = 3'd2,
    S_RND  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam int          FP32_BIAS    = 127;
  localparam logic [31:0] FP32_QNAN    = 32'h7FC0_0000;
  localparam logic [7:0]  FP32_EXP_MAX = 8'hFF;

  localparam int F_INV = 4;
  localparam int F_DVZ = 3;
  localparam int F_OVF = 2;
  localparam int F_UNF = 1;
  localparam int F_INX = 0;

endpackage

// File: rtl/rne_rounder_24.sv
// Round-to-nearest-even on a 24-bit significand.
// A carry out renormalizes the significand to 1.0.
module rne_rounder_24 (
  input  logic [23:0] mant,
  input  logic        guard,
  input  logic        sticky,
  output logic [23:0] mant_rnd,
  output logic        carry,
  output logic        inexact
);

  logic        up;
  logic [24:0] sum;

  assign up       = guard & (sticky | mant[0]);
  assign sum      = {1'b0, mant} + {24'd0, up};
  assign carry    = sum[24];
  assign mant_rnd = carry ? 24'h80_0000 : sum[23:0];
  assign inexact  = guard | sticky;

endmodule

// File: rtl/srt_fp32_result_packer.sv
// SRT divider back end: remainder correction, normalize,
// RNE rounding and binary32 packing with exception flags.
module srt_fp32_result_packer
  import srt_fp32_pkg::*;
#(
  parameter int QW = 28,
  parameter int EW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [QW-1:0] in_quotient,
  input  logic          in_rem_neg,
  input  logic          in_rem_nz,
  input  logic [EW-1:0] in_exp,
  input  logic          in_sign,
  input  special_e      in_special,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_result,
  output logic [4:0]    out_flags
);

  localparam int XW = EW + 1;
  localparam logic [QW-1:0] MASK_HI = {QW{1'b1}} >> 26;
  localparam logic [QW-1:0] MASK_LO = {QW{1'b1}} >> 27;
  localparam logic signed [XW-1:0] EXP_OVF = XW'(255);

  state_e state, state_nx;

  logic [QW-1:0]          q;
  logic                   rem_neg, rem_nz, sticky0, sign;
  logic signed [XW-1:0]   exp, exp_rnd;
  logic [23:0]            mant, mant_rnd;
  logic                   guard, sticky, carry, inexact;
  logic [31:0]            res_nx;
  logic [4:0]             flg_nx;
  logic                   accept, enter_done;
  logic                   unused_bits;

  assign accept     = in_valid & in_ready;
  assign enter_done = (state_nx == S_DONE) && (state != S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (in_valid)
                state_nx = (in_special == SP_NORMAL) ? S_CORR : S_DONE;
      S_CORR: state_nx = S_NORM;
      S_NORM: state_nx = S_RND;
      S_RND:  state_nx = S_DONE;
      S_DONE: if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (1'b1)
      (state == S_IDLE): in_ready  = 1'b1;
      (state == S_DONE): out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q       <= '0;
      rem_neg <= 1'b0;
      rem_nz  <= 1'b0;
      sticky0 <= 1'b0;
      sign    <= 1'b0;
      exp     <= '0;
      mant    <= '0;
      guard   <= 1'b0;
      sticky  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (accept) begin
          q       <= in_quotient;
          rem_neg <= in_rem_neg;
          rem_nz  <= in_rem_nz;
          sign    <= in_sign;
          exp     <= {in_exp[EW-1], in_exp};
        end
        S_CORR: begin
          q       <= q - {{(QW-1){1'b0}}, rem_neg};
          sticky0 <= rem_nz | rem_neg;
        end
        S_NORM: begin
          if (q[QW-2]) begin
            mant   <= q[QW-2 -: 24];
            guard  <= q[QW-26];
            sticky <= sticky0 | (|(q & MASK_HI));
          end else begin
            mant   <= q[QW-3 -: 24];
            guard  <= q[QW-27];
            sticky <= sticky0 | (|(q & MASK_LO));
            exp    <= exp - XW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  rne_rounder_24 u_rnd (
    .mant     (mant),
    .guard    (guard),
    .sticky   (sticky),
    .mant_rnd (mant_rnd),
    .carry    (carry),
    .inexact  (inexact)
  );

  assign exp_rnd = exp + {{(XW-1){1'b0}}, carry};
  // MSB of q is always 0 for a legal quotient; hidden bit is implied
  assign unused_bits = ^{q[QW-1], mant_rnd[23]};

  always_comb begin
    res_nx = '0;
    flg_nx = '0;
    if (state == S_RND) begin
      if (exp_rnd >= EXP_OVF) begin
        res_nx        = {sign, FP32_EXP_MAX, 23'h0};
        flg_nx[F_OVF] = 1'b1;
        flg_nx[F_INX] = 1'b1;
      end else if (exp_rnd[XW-1] || exp_rnd == '0) begin
        res_nx        = {sign, 31'h0};
        flg_nx[F_UNF] = 1'b1;
        flg_nx[F_INX] = 1'b1;
      end else begin
        res_nx        = {sign, exp_rnd[7:0], mant_rnd[22:0]};
        flg_nx[F_INX] = inexact;
      end
    end else begin
      unique case (in_special)
        SP_ZERO: res_nx = {in_sign, 31'h0};
        SP_INF:  res_nx = {in_sign, FP32_EXP_MAX, 23'h0};
        SP_QNAN: begin
          res_nx        = FP32_QNAN;
          flg_nx[F_INV] = 1'b1;
        end
        SP_DIVZ: begin
          res_nx        = {in_sign, FP32_EXP_MAX, 23'h0};
          flg_nx[F_DVZ] = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_result <= '0;
      out_flags  <= '0;
    end else if (enter_done) begin
      out_result <= res_nx;
      out_flags  <= flg_nx;
    end
  end

endmodule
